// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported synchronous memory between
// the instruction-fetch and data load/store requesters, one transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [2:0] LP_LAT = 3'(RD_LAT);

  state_t              r_state;
  state_t              w_next;
  logic                r_last_d;
  logic                r_sel_d;
  logic                r_is_wr;
  logic [2:0]          r_cnt;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_ack;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_d_req;
  logic                w_grant_d;

  assign w_d_req = d_read | d_write;
  // On a tie, data wins unless data was the last tie winner.
  assign w_grant_d = w_d_req & (~if_req | ~r_last_d);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (if_req | w_d_req) w_next = S_ISSUE;
      S_ISSUE: w_next = r_is_wr ? S_ACK : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b0;
      r_sel_d     <= 1'b0;
      r_is_wr     <= 1'b0;
      r_cnt       <= 3'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state  <= w_next;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_req | w_d_req) begin
            r_sel_d    <= w_grant_d;
            r_is_wr    <= w_grant_d & d_write;
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_grant_d & d_write;
            r_mem_addr <= w_grant_d ? d_addr : if_addr;
            if (w_grant_d & d_write) r_mem_wdata <= d_wdata;
            if (if_req & w_d_req) r_last_d <= w_grant_d;
          end
        end
        S_ISSUE: begin
          if (r_is_wr) r_d_ack <= 1'b1;
          else r_cnt <= LP_LAT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            if (r_sel_d) begin
              r_d_rdata <= mem_rdata;
              r_d_ack   <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata;
              r_if_ack   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall     = (if_req & ~r_if_ack) | (w_d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: memory model plus issue/ack queues,
// with two extra instances covering the RD_LAT=1 and RD_LAT=7 latencies.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 2;

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } iss_t;
  typedef struct { int cyc; logic port_d; logic [31:0] data; } ack_t;

  logic clk = 1'b0;
  logic reset;
  logic if_req, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_ack, d_ack, mem_en, mem_we, stall;

  // latency-build instances
  logic        l1_rd, l7_rd;
  logic [31:0] l1_mrd, l7_mrd;
  logic [31:0] l1_ifr, l1_dr, l1_ma, l1_mw, l7_ifr, l7_dr, l7_ma, l7_mw;
  logic        l1_ifa, l1_da, l1_me, l1_mwe, l1_st, l7_ifa, l7_da, l7_me, l7_mwe, l7_st;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  iss_t iss_q[$];
  ack_t ack_q[$];
  logic [31:0] mem [logic [31:0]];
  logic        pend_v = 1'b0;
  int          pend_cyc = 0;
  logic [31:0] pend_val = 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .if_req(1'b0), .if_addr(32'h0), .if_rdata(l1_ifr),
    .if_ack(l1_ifa), .d_read(l1_rd), .d_write(1'b0), .d_addr(32'h40), .d_wdata(32'h0),
    .d_rdata(l1_dr), .d_ack(l1_da), .mem_en(l1_me), .mem_we(l1_mwe), .mem_addr(l1_ma),
    .mem_wdata(l1_mw), .mem_rdata(l1_mrd), .stall(l1_st));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(7)) u_l7 (
    .clk(clk), .reset(reset), .if_req(1'b0), .if_addr(32'h0), .if_rdata(l7_ifr),
    .if_ack(l7_ifa), .d_read(l7_rd), .d_write(1'b0), .d_addr(32'h40), .d_wdata(32'h0),
    .d_rdata(l7_dr), .d_ack(l7_da), .mem_en(l7_me), .mem_we(l7_mwe), .mem_addr(l7_ma),
    .mem_wdata(l7_mw), .mem_rdata(l7_mrd), .stall(l7_st));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory read data: valid only in the cycle RD_LAT after the issue cycle.
  always begin
    @(posedge clk);
    #1;
    if (pend_v && cyc == pend_cyc) mem_rdata = pend_val;
    else mem_rdata = {16'hBAD0, cyc[15:0]};
  end

  // Monitor: compare every memory issue and every ack against the queues.
  always @(negedge clk) begin
    if (mem_en) begin
      if (iss_q.size() == 0) chk("issue_unexpected", {32'h0, mem_addr}, 64'hFFFF_FFFF);
      else begin
        iss_t e;
        e = iss_q.pop_front();
        chk("issue_cycle", 64'(cyc), 64'(e.cyc));
        chk("issue_we", {63'h0, mem_we}, {63'h0, e.we});
        chk("issue_addr", {32'h0, mem_addr}, {32'h0, e.addr});
        if (e.we) chk("issue_wdata", {32'h0, mem_wdata}, {32'h0, e.wdata});
      end
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin
        pend_v   = 1'b1;
        pend_cyc = cyc + RD_LAT;
        pend_val = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      end
    end
    if (if_ack || d_ack) begin
      chk("ack_single_port", {63'h0, if_ack & d_ack}, 64'h0);
      if (ack_q.size() == 0) chk("ack_unexpected", {62'h0, if_ack, d_ack}, 64'h0);
      else begin
        ack_t a;
        a = ack_q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(a.cyc));
        chk("ack_port", {63'h0, d_ack}, {63'h0, a.port_d});
        chk("ack_rdata", {32'h0, (d_ack ? d_rdata : if_rdata)}, {32'h0, a.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic exp_iss(input int c, input logic we, input logic [31:0] a, input logic [31:0] w);
    iss_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = w;
    iss_q.push_back(e);
  endtask

  task automatic exp_ack(input int c, input logic pd, input logic [31:0] d);
    ack_t e;
    e.cyc = c; e.port_d = pd; e.data = d;
    ack_q.push_back(e);
  endtask

  initial begin
    int t0;
    int c1, c7, n1, n7;
    logic [31:0] v1, v7;
    mem[32'h10]  = 32'hE3A00001;
    mem[32'h4]   = 32'h11110004;
    mem[32'h8]   = 32'h33330008;
    mem[32'h100] = 32'h22220100;
    mem[32'h108] = 32'h44440108;
    reset = 1'b1; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    l1_rd = 1'b0; l7_rd = 1'b0; l1_mrd = 32'h0; l7_mrd = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_en", {63'h0, mem_en}, 64'h0);
    chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    chk("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    chk("rst_acks", {62'h0, if_ack, d_ack}, 64'h0);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    tick(); reset = 1'b0;

    // single fetch with per-cycle stall profile
    tick(); t0 = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    exp_iss(t0 + 1, 1'b0, 32'h10, 32'h0);
    exp_ack(t0 + 4, 1'b0, 32'hE3A00001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_fetch", {63'h0, stall}, {63'h0, (i < 4)});
    end
    tick(); if_req = 1'b0;

    // single write; d_rdata still at its reset value
    tick(); t0 = cyc;
    d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    exp_iss(t0 + 1, 1'b1, 32'h200, 32'hDEADBEEF);
    exp_ack(t0 + 2, 1'b1, 32'h0);
    wait_cyc(t0 + 2); tick(); d_write = 1'b0;

    // tie after reset goes to data, then the next tie goes to fetch
    tick(); t0 = cyc;
    if_req = 1'b1; if_addr = 32'h4; d_read = 1'b1; d_addr = 32'h100;
    exp_iss(t0 + 1, 1'b0, 32'h100, 32'h0);
    exp_ack(t0 + 4, 1'b1, 32'h22220100);
    exp_iss(t0 + 6, 1'b0, 32'h4, 32'h0);
    exp_ack(t0 + 9, 1'b0, 32'h11110004);
    wait_cyc(t0 + 4); tick(); d_read = 1'b0;
    @(negedge clk);
    chk("stall_loser_pending", {63'h0, stall}, 64'h1);
    wait_cyc(t0 + 9); tick();
    if_addr = 32'h8; d_read = 1'b1; d_addr = 32'h108;
    exp_iss(t0 + 11, 1'b0, 32'h8, 32'h0);
    exp_ack(t0 + 14, 1'b0, 32'h33330008);
    exp_iss(t0 + 16, 1'b0, 32'h108, 32'h0);
    exp_ack(t0 + 19, 1'b1, 32'h44440108);
    wait_cyc(t0 + 14); tick(); if_req = 1'b0;
    wait_cyc(t0 + 19); tick(); d_read = 1'b0;

    // address change while the transaction is pending is ignored
    tick(); t0 = cyc;
    d_read = 1'b1; d_addr = 32'h100;
    exp_iss(t0 + 1, 1'b0, 32'h100, 32'h0);
    exp_ack(t0 + 4, 1'b1, 32'h22220100);
    tick(); d_addr = 32'h104;
    wait_cyc(t0 + 4); tick(); d_read = 1'b0;

    // read and write together act as a write; read it back afterwards
    tick(); t0 = cyc;
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFEF00D;
    exp_iss(t0 + 1, 1'b1, 32'h300, 32'hCAFEF00D);
    exp_ack(t0 + 2, 1'b1, 32'h22220100);
    wait_cyc(t0 + 2); tick(); d_read = 1'b0; d_write = 1'b0;
    tick(); t0 = cyc;
    d_read = 1'b1; d_addr = 32'h300;
    exp_iss(t0 + 1, 1'b0, 32'h300, 32'h0);
    exp_ack(t0 + 4, 1'b1, 32'hCAFEF00D);
    wait_cyc(t0 + 4); tick(); d_read = 1'b0;

    // fetch request dropped early still completes
    tick(); t0 = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    exp_iss(t0 + 1, 1'b0, 32'h10, 32'h0);
    exp_ack(t0 + 4, 1'b0, 32'hE3A00001);
    tick(); if_req = 1'b0;
    wait_cyc(t0 + 4);
    @(negedge clk);
    chk("rdata_retained_if", {32'h0, if_rdata}, 64'hE3A00001);

    // reset during the issue cycle aborts the read
    tick(); t0 = cyc;
    d_read = 1'b1; d_addr = 32'h100;
    exp_iss(t0 + 1, 1'b0, 32'h100, 32'h0);
    tick(); reset = 1'b1; d_read = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_mem_en", {63'h0, mem_en}, 64'h0);
    chk("midrst_acks", {62'h0, if_ack, d_ack}, 64'h0);
    chk("midrst_rdata", {if_rdata, d_rdata}, 64'h0);
    tick(); reset = 1'b0;
    repeat (8) tick();
    chk("iss_queue_drained", 64'(iss_q.size()), 64'h0);
    chk("ack_queue_drained", 64'(ack_q.size()), 64'h0);

    // RD_LAT=1 and RD_LAT=7 builds
    tick(); t0 = cyc;
    c1 = -1; c7 = -1; n1 = 0; n7 = 0; v1 = 32'h0; v7 = 32'h0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      l1_rd  = (k <= 3);
      l7_rd  = (k <= 9);
      l1_mrd = (k == 2) ? 32'hA5A50001 : 32'h0BADBAD1;
      l7_mrd = (k == 8) ? 32'hA5A50007 : 32'h0BADBAD7;
      @(negedge clk);
      if (l1_da) begin n1++; c1 = k; v1 = l1_dr; end
      if (l7_da) begin n7++; c7 = k; v7 = l7_dr; end
    end
    l1_rd = 1'b0; l7_rd = 1'b0;
    chk("lat1_ack_cycle", 64'(c1), 64'd3);
    chk("lat1_rdata", {32'h0, v1}, 64'hA5A50001);
    chk("lat1_ack_count", 64'(n1), 64'd1);
    chk("lat7_ack_cycle", 64'(c7), 64'd9);
    chk("lat7_rdata", {32'h0, v7}, 64'hA5A50007);
    chk("lat7_ack_count", 64'(n7), 64'd1);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the instruction-fetch requester and the data load/store requester of the SCC core.
- Sits between the core (IF stage fetch path, ID stage data_read/data_write path) and the unified memory macro.
- Performs round-robin arbitration and issues one memory transaction at a time.
- Returns read data and a one-cycle ack to the winner; drives a stall the top level ANDs into the functional clock, the same way halt gates it.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
RD_LAT, 2, cycles from the cycle mem_en is high (read) to the cycle mem_rdata is valid; legal range 1..7

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held high until if_ack
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched instruction, valid while if_ack=1
if_ack  output  1  one-cycle fetch completion
d_read  input  1  data read request; held until d_ack
d_write  input  1  data write request; held until d_ack
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_rdata  output  DATA_W  read data, valid while d_ack=1
d_ack  output  1  one-cycle data completion
mem_en  output  1  memory access strobe
mem_we  output  1  write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
stall  output  1  combinational: (if_req & ~if_ack) | ((d_read|d_write) & ~d_ack)

Behaviour:
- Reset and outputs:
  - State machine IDLE, ISSUE, WAIT, ACK. Reset -> IDLE.
  - All registered outputs reset to 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata.
  - Reset sets last_grant=IF, so data wins the first tie.
- IDLE:
  - Sample requests. None -> stay in IDLE.
  - One requester -> grant it. Both -> grant the requester not equal to last_grant, then update last_grant.
  - On grant, latch addr, write data and type. Next state ISSUE.
  - Later changes to the requester's inputs are ignored until ack.
- ISSUE: exactly one cycle.
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the latch.
  - Write -> ACK.
  - Read -> WAIT with counter=RD_LAT.
- WAIT:
  - mem_en=0; counter decrements each cycle.
  - In the cycle counter==1, capture mem_rdata into the winner's rdata register at the clock edge, then go to ACK.
  - WAIT therefore lasts RD_LAT cycles.
- ACK: one cycle.
  - The winner's ack=1 and rdata holds the captured value. After a write, d_rdata is unchanged.
  - Next state IDLE; no arbitration happens in ACK.
  - Requesters must drop or renew their request on the edge ending the ack cycle.
  - A request still high in the following IDLE cycle is a new request.
- Latency: request seen in IDLE at cycle T.
  - Write: ack at T+2.
  - Read: ack at T+2+RD_LAT.
  - Back-to-back requests from one requester: one transaction per RD_LAT+3 cycles for reads, 3 cycles for writes.
- Boundary cases:
  - d_read & d_write both high: treated as a write.
  - Request deasserted before ack (protocol violation): transaction still completes and ack still pulses.
  - Loser's request: held pending, and stall stays high for it.
  - Reset mid-transaction: abort. mem_en=0 and no ack from the next cycle; rdata registers cleared.
  - if_rdata / d_rdata retain their value after ack until the next capture for that port.
- Address/data widths: passed through unchanged, no arithmetic. The counter is 3 bits.

Test Plan:
- Reset: hold reset 2 cycles mid-read (ISSUE state) -> next cycle mem_en=0, acks 0, rdata 0, state IDLE; no ack appears afterwards.
- Single fetch, RD_LAT=2: if_req=1, if_addr=0x10 at cycle 0; mem_rdata=0xE3A00001 in cycle 3 -> mem_en=1, mem_addr=0x10 in cycle 1, mem_we=0; if_ack=1 with if_rdata=0xE3A00001 in cycle 4; stall=1 cycles 0-3, 0 in cycle 4.
- Single write: d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF at cycle 0 -> cycle 1 mem_en=1, mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF; d_ack=1 in cycle 2; if_ack stays 0.
- Tie after reset: if_req and d_read both high at cycle 0 (addrs 0x4 / 0x100) -> data served first (d_ack cycle 4); fetch issued cycle 6 with mem_addr=0x4, if_ack cycle 9. A second tie then goes to IF, so the grant alternates.
- Address change while pending: d_read at 0x100, d_addr changed to 0x104 in cycle 1 -> mem_addr=0x100 in the issue cycle.
- RD_LAT=1 and RD_LAT=7 builds: read at cycle 0 -> ack at cycle 3 and cycle 9 respectively; rdata equals the mem_rdata value presented in cycle 1+RD_LAT.
